// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - programmable start/stop/resume/clear sequencer around an up-counter
module counter_ctrl #(
    parameter int WIDTH  = 4,
    parameter int PCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_limit,
    input  logic              cmd_auto,
    output logic [WIDTH-1:0]  count,
    output logic              busy,
    output logic              paused,
    output logic              done,
    output logic              tc_pulse,
    output logic [PCNT_W-1:0] periods
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_STOP   = 2'b01;
    localparam logic [1:0] OP_RESUME = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    state_t             state;
    logic [WIDTH-1:0]   limit_r;
    logic               auto_r;
    logic               accept;

    assign accept = cmd_valid && cmd_ready;

    // Command decode, counting and terminal-count handling; status flags are
    // registered alongside every state transition so they always match state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            limit_r   <= '0;
            auto_r    <= 1'b0;
            tc_pulse  <= 1'b0;
            periods   <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            paused    <= 1'b0;
            done      <= 1'b0;
        end else begin
            tc_pulse  <= 1'b0;
            // One-cycle hold-off after every accepted command.
            cmd_ready <= !accept;
            if (accept) begin
                // An accepted command wins over a terminal count in the same cycle.
                case (cmd_op)
                    OP_START: begin
                        limit_r <= cmd_limit;
                        auto_r  <= cmd_auto;
                        count   <= '0;
                        periods <= '0;
                        state   <= RUN;
                        busy    <= 1'b1;
                        paused  <= 1'b0;
                        done    <= 1'b0;
                    end
                    OP_STOP: begin
                        if (state == RUN) begin
                            state  <= PAUSE;
                            busy   <= 1'b0;
                            paused <= 1'b1;
                        end
                    end
                    OP_RESUME: begin
                        if (state == PAUSE) begin
                            state  <= RUN;
                            busy   <= 1'b1;
                            paused <= 1'b0;
                        end
                    end
                    OP_CLEAR: begin
                        state   <= IDLE;
                        count   <= '0;
                        periods <= '0;
                        busy    <= 1'b0;
                        paused  <= 1'b0;
                        done    <= 1'b0;
                    end
                endcase
            end else if (state == RUN) begin
                if (count != limit_r) begin
                    count <= count + WIDTH'(1);
                end else begin
                    tc_pulse <= 1'b1;
                    if (periods != {PCNT_W{1'b1}}) begin
                        periods <= periods + PCNT_W'(1);
                    end
                    if (auto_r) begin
                        count <= '0;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - scoreboard bench for counter_ctrl
module tb_counter_ctrl;

    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_STOP   = 2'b01;
    localparam logic [1:0] OP_RESUME = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_limit;
    logic       cmd_auto;
    logic [3:0] count;
    logic       busy;
    logic       paused;
    logic       done;
    logic       tc_pulse;
    logic [7:0] periods;

    typedef struct {
        int         id;
        logic [3:0] count;
        logic [2:0] flags;
        logic       tc;
        logic [7:0] periods;
        logic       rdy;
    } exp_t;

    exp_t expq[$];
    int   checks   = 0;
    int   failures = 0;
    int   stepno   = 0;

    counter_ctrl #(.WIDTH(4), .PCNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_limit (cmd_limit),
        .cmd_auto  (cmd_auto),
        .count     (count),
        .busy      (busy),
        .paused    (paused),
        .done      (done),
        .tc_pulse  (tc_pulse),
        .periods   (periods)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int id, input int got, input int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s step=%0d got=%0d expected=%0d", name, id, got, expv);
        end
    endtask

    function automatic logic [2:0] flags_of(input int st);
        case (st)
            S_RUN:   return 3'b100;
            S_PAUSE: return 3'b010;
            S_DONE:  return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Drive one cycle of inputs and queue what the outputs must be after the next edge.
    task automatic step(input logic r, input logic v, input logic [1:0] op, input logic [3:0] lim,
                        input logic au, input int ec, input int est, input logic etc,
                        input int eper, input logic erdy);
        exp_t e;
        rst       = r;
        cmd_valid = v;
        cmd_op    = op;
        cmd_limit = lim;
        cmd_auto  = au;
        e.id      = stepno;
        e.count   = 4'(ec);
        e.flags   = flags_of(est);
        e.tc      = etc;
        e.periods = 8'(eper);
        e.rdy     = erdy;
        stepno++;
        expq.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int ec, input int est, input logic etc, input int eper, input logic erdy);
        step(1'b0, 1'b0, OP_START, 4'd0, 1'b0, ec, est, etc, eper, erdy);
    endtask

    task automatic cmd(input logic [1:0] op, input logic [3:0] lim, input logic au,
                       input int ec, input int est, input int eper, input logic erdy);
        step(1'b0, 1'b1, op, lim, au, ec, est, 1'b0, eper, erdy);
    endtask

    // Monitor: outputs settle on the rising edge, so compare on the falling edge.
    always @(negedge clk) begin
        if (expq.size() != 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("count",     e.id, int'(count),                  int'(e.count));
            chk("flags",     e.id, int'({busy, paused, done}),   int'(e.flags));
            chk("tc_pulse",  e.id, int'(tc_pulse),               int'(e.tc));
            chk("periods",   e.id, int'(periods),                int'(e.periods));
            chk("cmd_ready", e.id, int'(cmd_ready),              int'(e.rdy));
        end
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_limit = 4'd0; cmd_auto = 1'b0;

        // Reset state
        step(1'b1, 1'b0, OP_START, 4'd0, 1'b0, 0, S_IDLE, 1'b0, 0, 1'b1);
        step(1'b1, 1'b0, OP_START, 4'd0, 1'b0, 0, S_IDLE, 1'b0, 0, 1'b1);
        idle(0, S_IDLE, 1'b0, 0, 1'b1);

        // One-shot, limit 5
        cmd(OP_START, 4'd5, 1'b0, 0, S_RUN, 0, 1'b0);
        for (int i = 1; i <= 5; i++) idle(i, S_RUN, 1'b0, 0, 1'b1);
        idle(5, S_DONE, 1'b1, 1, 1'b1);
        idle(5, S_DONE, 1'b0, 1, 1'b1);
        idle(5, S_DONE, 1'b0, 1, 1'b1);

        // Auto-reload, limit 3, run past 255 periods to see saturation
        cmd(OP_START, 4'd3, 1'b1, 0, S_RUN, 0, 1'b0);
        for (int j = 1; j <= 1220; j++)
            idle(j % 4, S_RUN, (j % 4) == 0, (j / 4 > 255) ? 255 : j / 4, 1'b1);

        // Pause at 7, hold, resume to terminal count
        cmd(OP_START, 4'd15, 1'b0, 0, S_RUN, 0, 1'b0);
        for (int i = 1; i <= 7; i++) idle(i, S_RUN, 1'b0, 0, 1'b1);
        cmd(OP_STOP, 4'd0, 1'b0, 7, S_PAUSE, 0, 1'b0);
        for (int i = 0; i < 10; i++) idle(7, S_PAUSE, 1'b0, 0, 1'b1);
        cmd(OP_RESUME, 4'd0, 1'b0, 7, S_RUN, 0, 1'b0);
        for (int i = 8; i <= 15; i++) idle(i, S_RUN, 1'b0, 0, 1'b1);
        idle(15, S_DONE, 1'b1, 1, 1'b1);
        idle(15, S_DONE, 1'b0, 1, 1'b1);

        // Clear from DONE, then continuous cmd_valid handshake
        cmd(OP_CLEAR, 4'd0, 1'b0, 0, S_IDLE, 0, 1'b0);
        cmd(OP_STOP, 4'd0, 1'b0, 0, S_IDLE, 0, 1'b1);
        cmd(OP_STOP, 4'd0, 1'b0, 0, S_IDLE, 0, 1'b0);
        cmd(OP_STOP, 4'd0, 1'b0, 0, S_IDLE, 0, 1'b1);
        cmd(OP_STOP, 4'd0, 1'b0, 0, S_IDLE, 0, 1'b0);
        cmd(OP_START, 4'd9, 1'b0, 0, S_IDLE, 0, 1'b1);
        cmd(OP_START, 4'd9, 1'b0, 0, S_RUN, 0, 1'b0);
        cmd(OP_START, 4'd9, 1'b0, 1, S_RUN, 0, 1'b1);
        cmd(OP_RESUME, 4'd0, 1'b0, 1, S_RUN, 0, 1'b0);
        for (int i = 2; i <= 9; i++) idle(i, S_RUN, 1'b0, 0, 1'b1);

        // Reset mid-run at count 9, with a command that would otherwise be accepted
        step(1'b1, 1'b1, OP_START, 4'd4, 1'b1, 0, S_IDLE, 1'b0, 0, 1'b1);
        idle(0, S_IDLE, 1'b0, 0, 1'b1);

        // STOP colliding with terminal count
        cmd(OP_START, 4'd2, 1'b1, 0, S_RUN, 0, 1'b0);
        idle(1, S_RUN, 1'b0, 0, 1'b1);
        idle(2, S_RUN, 1'b0, 0, 1'b1);
        idle(0, S_RUN, 1'b1, 1, 1'b1);
        idle(1, S_RUN, 1'b0, 1, 1'b1);
        idle(2, S_RUN, 1'b0, 1, 1'b1);
        cmd(OP_STOP, 4'd0, 1'b0, 2, S_PAUSE, 1, 1'b0);
        idle(2, S_PAUSE, 1'b0, 1, 1'b1);
        cmd(OP_RESUME, 4'd0, 1'b0, 2, S_RUN, 1, 1'b0);
        idle(0, S_RUN, 1'b1, 2, 1'b1);

        // Limit 0 auto-reload: terminal count every cycle, periods saturate
        cmd(OP_START, 4'd0, 1'b1, 0, S_RUN, 0, 1'b0);
        for (int j = 1; j <= 300; j++) idle(0, S_RUN, 1'b1, (j > 255) ? 255 : j, 1'b1);

        // Limit 0 one-shot, then CLEAR from DONE
        cmd(OP_START, 4'd0, 1'b0, 0, S_RUN, 0, 1'b0);
        idle(0, S_DONE, 1'b1, 1, 1'b1);
        idle(0, S_DONE, 1'b0, 1, 1'b1);
        cmd(OP_CLEAR, 4'd0, 1'b0, 0, S_IDLE, 0, 1'b0);
        idle(0, S_IDLE, 1'b0, 0, 1'b1);

        #1;
        for (int i = 0; i < 10 && expq.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("drain", stepno, expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
